alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one instance of the team's 32-bit ALU between two requesters: port 0 is the core execute stage, port 1 is an auxiliary unit such as multdiv or address generation.
- Arbitration is round-robin, with an optional bounded lock so one port can issue back-to-back bursts.
- Each accepted operation completes in exactly one cycle. The result and the ALU flags are registered and returned to the issuing port with its tag.
- Sits between the decode/issue logic and the ALU. The ALU is instantiated inside this block.

Parameters:
- TAG_W, default 4: width of the per-request tag echoed back with the response.
- LOCK_MAX, default 8: maximum consecutive grants a locked port may hold while the other port is requesting.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid_p0 / req_valid_p1, in, 1 each: request present.
- req_ready_p0 / req_ready_p1, out, 1 each: grant; the request is accepted on the clock edge where valid and ready are both high.
- req_lock_p0 / req_lock_p1, in, 1 each: when high with an accepted request, the port asks to keep the grant next cycle.
- req_opA_p0 / req_opA_p1, in, 32 each: operand A.
- req_opB_p0 / req_opB_p1, in, 32 each: operand B.
- req_opcode_p0 / req_opcode_p1, in, 5 each: ALU opcode.
- req_shamt_p0 / req_shamt_p1, in, 5 each: shift amount.
- req_tag_p0 / req_tag_p1, in, TAG_W each: request tag.
- resp_valid_p0 / resp_valid_p1, out, 1 each: one-cycle response pulse.
- resp_result, out, 32: registered ALU result.
- resp_ne, out, 1: registered isNotEqual.
- resp_lt, out, 1: registered isLessThan.
- resp_ovf, out, 1: registered overflow.
- resp_err, out, 1: illegal opcode flag.
- resp_tag, out, TAG_W: echoed tag.

Behaviour:
- Reset (reset low, asynchronous):
  - All resp_* outputs go to 0.
  - The priority pointer selects port 0.
  - The lock state is cleared and the lock counter is 0.
  - req_ready_* are combinational and follow the rules below even during reset; requests accepted while reset is low are discarded.
- Opcode map, per the ALU:
  - 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra.
  - Opcodes 6 and 7 are legal and produce result 0.
  - An opcode with bit 4 or bit 3 set is illegal: response has resp_err=1, resp_result=0, and all flags 0.
- Grant, combinational within a cycle:
  - If only one port is valid, it is granted.
  - If both are valid and a lock is held by port k, port k is granted.
  - If both are valid and no lock is held, the pointer port is granted.
  - At most one req_ready is high in any cycle. With no valid requests, both ready signals are 0.
- Pointer update on an accepted request: the pointer moves to the other port. Exception: while the granted port's lock is held, the pointer does not move.
- Lock rules:
  - Accepting a request with req_lock=1 sets the lock for that port.
  - Accepting a request with req_lock=0 clears the lock.
  - Each consecutive locked grant taken while the other port is valid increments the lock counter.
  - When the counter reaches LOCK_MAX, the lock is cleared and the pointer is forced to the other port for the next cycle. That forced grant is not pre-empted.
  - The counter resets to 0 on lock clear or on a cycle in which the other port is not valid.
  - The lock is also cleared if the locked port drops req_valid.
- Datapath:
  - The granted port's operands, opcode and shift amount drive the ALU combinationally.
  - On the acceptance edge, the result, the three flags, the tag and the port id are registered.
  - resp_valid of the issuing port is high for exactly the next cycle. Latency is 1 and throughput is 1 op per cycle.
  - There is no response backpressure; requesters must capture the response in its pulse cycle.
  - resp_* hold their last value when no response is valid.
- Flag semantics:
  - resp_ne and resp_lt are meaningful for sub only.
  - resp_ovf is meaningful for add and sub.
  - For all other opcodes the flags are passed through unmodified from the ALU.
- Simultaneous events:
  - A new acceptance in the same cycle a response is pulsing is legal; the response registers are overwritten at that edge.
  - Reset in mid-burst drops the pending response, so no resp_valid pulse is produced after reset deasserts.

Decomposition:
- Shared package holds:
  - The opcode constants (ADD=5'd0, SUB=5'd1, AND=5'd2, OR=5'd3, SLL=5'd4, SRA=5'd5).
  - An is_legal_opcode function.
  - Port-id constants P0=1'b0 and P1=1'b1.
- One sub-module, rr_lock_arb, contains the grant logic, pointer, lock and counter. The top module holds the operand mux, the ALU instance and the response registers.

Test Plan:
- Single-port add: p0 issues opA=7, opB=5, opcode 0, tag 3 -> one cycle later resp_valid_p0=1, result=12, ovf=0, tag=3; resp_valid_p1 stays 0.
- Contention with pointer at p0: both ports valid continuously, unlocked -> grants alternate p0, p1, p0, p1; each response comes on the matching port with the correct tag.
- Sub flags: p1 issues sub with opA=0x7FFFFFFF, opB=0xFFFFFFFF -> result=0x80000000, ovf=1, lt=0, ne=1. Then sub 3-3 -> result 0, ne=0.
- Lock bound with LOCK_MAX=8: p0 holds lock=1 while p1 is valid -> p0 gets exactly 8 consecutive grants, then p1 is granted; lock counter returns to 0.
- Illegal opcode 5'b01000 from p0 -> resp_err=1, result=0, flags 0, response still delivered after 1 cycle.
- Reset mid-operation: accept a p1 request, assert reset low before the next edge -> no resp_valid pulse, all resp_* equal 0, next contended grant goes to p0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared opcode and port-id constants for the ALU share arbiter
// Purpose: opcode map of the 32-bit ALU, requester port ids and the opcode legality check.
// Contents: ADD/SUB/AND/OR/SLL/SRA opcodes, P0/P1 port ids, is_legal_opcode().
package alu_share_arb_pkg;

  localparam logic [4:0] ADD = 5'd0;
  localparam logic [4:0] SUB = 5'd1;
  localparam logic [4:0] AND = 5'd2;
  localparam logic [4:0] OR  = 5'd3;
  localparam logic [4:0] SLL = 5'd4;
  localparam logic [4:0] SRA = 5'd5;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Opcodes 0..7 are legal (6 and 7 return zero); anything with bit 3 or 4 set is not.
  function automatic logic is_legal_opcode(input logic [4:0] opcode);
    return !(opcode[4] || opcode[3]);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - two-port request/response bundle of the ALU share arbiter
// Purpose: groups both requester ports and the shared response bus.
// Signals: req_valid/ready/lock/opA/opB/opcode/shamt/tag per port (_p0, _p1),
//          resp_valid per port, shared resp_result/ne/lt/ovf/err/tag.
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arb_if #(
  parameter int TAG_W = 4
);
  logic             req_valid_p0,  req_valid_p1;
  logic             req_ready_p0,  req_ready_p1;
  logic             req_lock_p0,   req_lock_p1;
  logic [31:0]      req_opA_p0,    req_opA_p1;
  logic [31:0]      req_opB_p0,    req_opB_p1;
  logic [4:0]       req_opcode_p0, req_opcode_p1;
  logic [4:0]       req_shamt_p0,  req_shamt_p1;
  logic [TAG_W-1:0] req_tag_p0,    req_tag_p1;

  logic             resp_valid_p0, resp_valid_p1;
  logic [31:0]      resp_result;
  logic             resp_ne, resp_lt, resp_ovf, resp_err;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid_p0, req_valid_p1, req_lock_p0, req_lock_p1,
           req_opA_p0, req_opA_p1, req_opB_p0, req_opB_p1,
           req_opcode_p0, req_opcode_p1, req_shamt_p0, req_shamt_p1,
           req_tag_p0, req_tag_p1,
    input  req_ready_p0, req_ready_p1,
           resp_valid_p0, resp_valid_p1, resp_result,
           resp_ne, resp_lt, resp_ovf, resp_err, resp_tag
  );

  modport slave (
    input  req_valid_p0, req_valid_p1, req_lock_p0, req_lock_p1,
           req_opA_p0, req_opA_p1, req_opB_p0, req_opB_p1,
           req_opcode_p0, req_opcode_p1, req_shamt_p0, req_shamt_p1,
           req_tag_p0, req_tag_p1,
    output req_ready_p0, req_ready_p1,
           resp_valid_p0, resp_valid_p1, resp_result,
           resp_ne, resp_lt, resp_ovf, resp_err, resp_tag
  );

endinterface

// File: rtl/alu_share_arb_alu.sv
// rtl/alu_share_arb_alu.sv - combinational 32-bit ALU shared by both requesters
// Purpose: add/sub/and/or/sll/sra with isNotEqual, isLessThan (signed) and overflow flags.
// Ports: op_a, op_b, opcode, shamt in; result, ne, lt, ovf, err out.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  opcode,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        ne,
  output logic        lt,
  output logic        ovf,
  output logic        err
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    ne     = (op_a != op_b);
    lt     = ($signed(op_a) < $signed(op_b));
    err    = !is_legal_opcode(opcode);
    case (opcode)
      ADD: begin
        result = sum;
        ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      SUB: begin
        result = diff;
        ovf    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      AND:     result = op_a & op_b;
      OR:      result = op_a | op_b;
      SLL:     result = op_a << shamt;
      SRA:     result = $signed(op_a) >>> shamt;
      default: result = '0;
    endcase
    if (err) begin
      ne = 1'b0;
      lt = 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arb_rr_lock_arb.sv
// rtl/alu_share_arb_rr_lock_arb.sv - round-robin arbiter with bounded grant lock
// Purpose: picks one of two requesters per cycle; a port may lock the grant for
//          up to LOCK_MAX consecutive contended grants.
// Ports: clock, reset (async, active-low), valid[1:0], lock[1:0] in;
//        ready[1:0] (one-hot grant), gnt_id, accept out.
module rr_lock_arb
  import alu_share_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] ready,
  output logic       gnt_id,
  output logic       accept
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic             ptr;
  logic             lock_held;
  logic             lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             other_valid;

  always_comb begin
    gnt_id = P0;
    if (valid[0] && valid[1]) gnt_id = lock_held ? lock_owner : ptr;
    else if (valid[1])        gnt_id = P1;
    accept = valid[0] | valid[1];
    ready = 2'b00;
    if (accept) ready = (gnt_id == P1) ? 2'b10 : 2'b01;
    other_valid = (gnt_id == P1) ? valid[0] : valid[1];
    // A run only continues if the same port already holds the lock.
    cnt_inc = ((lock_held && lock_owner == gnt_id) ? lock_cnt : '0) + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr        <= P0;
      lock_held  <= 1'b0;
      lock_owner <= P0;
      lock_cnt   <= '0;
    end else if (!accept) begin
      // Nobody valid means the lock owner dropped its request.
      lock_held <= 1'b0;
      lock_cnt  <= '0;
    end else if (!lock[gnt_id]) begin
      lock_held <= 1'b0;
      lock_cnt  <= '0;
      ptr       <= ~gnt_id;
    end else if (!other_valid) begin
      // Uncontended locked grants hold the lock but do not use up the budget.
      lock_held  <= 1'b1;
      lock_owner <= gnt_id;
      lock_cnt   <= '0;
    end else if (cnt_inc == CNT_MAX) begin
      // Budget spent: hand the next contended grant to the other port.
      lock_held <= 1'b0;
      lock_cnt  <= '0;
      ptr       <= ~gnt_id;
    end else begin
      lock_held  <= 1'b1;
      lock_owner <= gnt_id;
      lock_cnt   <= cnt_inc;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one ALU between the execute stage (p0) and an aux unit (p1)
// Purpose: arbitrates two request ports, runs the granted op through the ALU and
//          returns a registered result, flags and tag one cycle later to the issuer.
// Ports: clock, reset (async, active-low); bus = alu_share_arb_if.slave carrying
//        both request ports and the shared response bus.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic             clock,
  input  logic             reset,
  alu_share_arb_if.slave   bus
);

  logic [1:0]       ready;
  logic             gnt_id;
  logic             accept;
  logic [31:0]      op_a, op_b;
  logic [4:0]       opcode, shamt;
  logic [TAG_W-1:0] tag;
  logic [31:0]      alu_result;
  logic             alu_ne, alu_lt, alu_ovf, alu_err;

  logic             resp_vld;
  logic             resp_port;
  logic [31:0]      resp_result;
  logic             resp_ne, resp_lt, resp_ovf, resp_err;
  logic [TAG_W-1:0] resp_tag;

  rr_lock_arb #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  ({bus.req_valid_p1, bus.req_valid_p0}),
    .lock   ({bus.req_lock_p1, bus.req_lock_p0}),
    .ready  (ready),
    .gnt_id (gnt_id),
    .accept (accept)
  );

  assign bus.req_ready_p0 = ready[0];
  assign bus.req_ready_p1 = ready[1];

  assign op_a   = (gnt_id == P1) ? bus.req_opA_p1    : bus.req_opA_p0;
  assign op_b   = (gnt_id == P1) ? bus.req_opB_p1    : bus.req_opB_p0;
  assign opcode = (gnt_id == P1) ? bus.req_opcode_p1 : bus.req_opcode_p0;
  assign shamt  = (gnt_id == P1) ? bus.req_shamt_p1  : bus.req_shamt_p0;
  assign tag    = (gnt_id == P1) ? bus.req_tag_p1    : bus.req_tag_p0;

  alu_share_arb_alu u_alu (
    .op_a   (op_a),
    .op_b   (op_b),
    .opcode (opcode),
    .shamt  (shamt),
    .result (alu_result),
    .ne     (alu_ne),
    .lt     (alu_lt),
    .ovf    (alu_ovf),
    .err    (alu_err)
  );

  // Payload holds between responses; only the valid pulse is cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_vld    <= 1'b0;
      resp_port   <= P0;
      resp_result <= '0;
      resp_ne     <= 1'b0;
      resp_lt     <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
      resp_tag    <= '0;
    end else begin
      resp_vld <= accept;
      if (accept) begin
        resp_port   <= gnt_id;
        resp_result <= alu_result;
        resp_ne     <= alu_ne;
        resp_lt     <= alu_lt;
        resp_ovf    <= alu_ovf;
        resp_err    <= alu_err;
        resp_tag    <= tag;
      end
    end
  end

  assign bus.resp_valid_p0 = resp_vld && (resp_port == P0);
  assign bus.resp_valid_p1 = resp_vld && (resp_port == P1);
  assign bus.resp_result   = resp_result;
  assign bus.resp_ne       = resp_ne;
  assign bus.resp_lt       = resp_lt;
  assign bus.resp_ovf      = resp_ovf;
  assign bus.resp_err      = resp_err;
  assign bus.resp_tag      = resp_tag;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int TAG_W    = 4;
  localparam int LOCK_MAX = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_share_arb_if #(.TAG_W(TAG_W)) bus ();

  alu_share_arb #(.TAG_W(TAG_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int               port;
    logic [31:0]      result;
    logic             ne, lt, ovf, err;
    logic [TAG_W-1:0] tag;
    logic [4:0]       op;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   checks   = 0;
  int   failures = 0;

  logic             v[2], lk[2];
  logic [31:0]      a[2], b[2];
  logic [4:0]       op[2], sh[2];
  logic [TAG_W-1:0] tg[2];

  int prio = 0;
  int lock_port = -1;
  int burst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_alu(input int port, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] o, input logic [4:0] s,
                                   input logic [TAG_W-1:0] t);
    exp_t   e;
    longint sx, sy, r;
    e.port = port; e.tag = t; e.op = o;
    e.result = '0; e.ne = 1'b0; e.lt = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o >= 5'd8) e.err = 1'b1;
    else begin
      case (o)
        5'd0: begin r = sx + sy; e.result = r[31:0]; e.ovf = (r != longint'($signed(e.result))); end
        5'd1: begin
          r = sx - sy; e.result = r[31:0]; e.ovf = (r != longint'($signed(e.result)));
          e.ne = (x != y); e.lt = (sx < sy);
        end
        5'd2: e.result = x & y;
        5'd3: e.result = x | y;
        5'd4: e.result = x << s;
        5'd5: begin r = sx >>> s; e.result = r[31:0]; end
        default: e.result = '0;
      endcase
    end
    return e;
  endfunction

  function automatic int model_grant();
    if (v[0] && v[1]) return (lock_port >= 0) ? lock_port : prio;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_accept(input int g);
    int o;
    o = 1 - g;
    if (!lk[g]) begin
      lock_port = -1; burst = 0; prio = o;
    end else if (!v[o]) begin
      lock_port = g; burst = 0;
    end else begin
      burst = ((lock_port == g) ? burst : 0) + 1;
      if (burst >= LOCK_MAX) begin lock_port = -1; burst = 0; prio = o; end
      else lock_port = g;
    end
  endtask

  task automatic drive();
    bus.req_valid_p0 = v[0];   bus.req_valid_p1 = v[1];
    bus.req_lock_p0 = lk[0];   bus.req_lock_p1 = lk[1];
    bus.req_opA_p0 = a[0];     bus.req_opA_p1 = a[1];
    bus.req_opB_p0 = b[0];     bus.req_opB_p1 = b[1];
    bus.req_opcode_p0 = op[0]; bus.req_opcode_p1 = op[1];
    bus.req_shamt_p0 = sh[0];  bus.req_shamt_p1 = sh[1];
    bus.req_tag_p0 = tg[0];    bus.req_tag_p1 = tg[1];
  endtask

  task automatic set_port(input int p, input logic val, input logic lck, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] o, input logic [TAG_W-1:0] t);
    v[p] = val; lk[p] = lck; a[p] = x; b[p] = y; op[p] = o; sh[p] = 5'd0; tg[p] = t;
  endtask

  task automatic step();
    int g, dg;
    @(negedge clock);
    drive();
    #1;
    g  = model_grant();
    dg = bus.req_ready_p1 ? 1 : (bus.req_ready_p0 ? 0 : -1);
    check("ready_p0", 64'(bus.req_ready_p0), 64'(g == 0));
    check("ready_p1", 64'(bus.req_ready_p1), 64'(g == 1));
    if (g >= 0) begin
      sb.push_back(ref_alu(g, a[g], b[g], op[g], sh[g], tg[g]));
      grants.push_back(dg);
      model_accept(g);
    end else begin
      lock_port = -1; burst = 0;
    end
  endtask

  task automatic check_resp_zero(input string name);
    check({name, "_valid"}, 64'({bus.resp_valid_p0, bus.resp_valid_p1}), 64'(0));
    check({name, "_result"}, 64'(bus.resp_result), 64'(0));
    check({name, "_tag_flags"}, 64'({bus.resp_tag, bus.resp_ne, bus.resp_lt, bus.resp_ovf, bus.resp_err}), 64'(0));
  endtask

  // Monitor: pops one expectation per response pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        if (bus.resp_valid_p0 || bus.resp_valid_p1) begin
          check("resp_onehot", 64'(bus.resp_valid_p0 & bus.resp_valid_p1), 64'(0));
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_unexpected actual=pulse required=none");
          end else begin
            e = sb.pop_front();
            check("resp_port", 64'(bus.resp_valid_p1), 64'(e.port));
            check("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
            check("resp_result", 64'(bus.resp_result), 64'(e.result));
            check("resp_err", 64'(bus.resp_err), 64'(e.err));
            if (e.err || e.op == SUB) begin
              check("resp_ne", 64'(bus.resp_ne), 64'(e.ne));
              check("resp_lt", 64'(bus.resp_lt), 64'(e.lt));
            end
            if (e.err || e.op == ADD || e.op == SUB)
              check("resp_ovf", 64'(bus.resp_ovf), 64'(e.ovf));
          end
        end else if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++; failures++;
          $display("FAIL resp_missing actual=none required=port%0d_tag%0h", e.port, e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, '0);
    drive();
    repeat (2) @(negedge clock);
    #1;
    check_resp_zero("reset");
    check("reset_ready_idle", 64'({bus.req_ready_p0, bus.req_ready_p1}), 64'(0));
    v[0] = 1'b1; drive(); #1;
    check("reset_ready_p0", 64'(bus.req_ready_p0), 64'(1));
    @(posedge clock); #1;
    check_resp_zero("reset_discard");
    v[0] = 1'b0; drive();
    @(negedge clock);
    reset = 1'b1;

    // Single-port add
    set_port(0, 1'b1, 1'b0, 32'd7, 32'd5, ADD, 4'd3);
    step();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, ADD, '0);
    step();

    // Sub flags on p1 (also returns the pointer to p0)
    set_port(1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, SUB, 4'd9);
    step();
    set_port(1, 1'b1, 1'b0, 32'd3, 32'd3, SUB, 4'd10);
    step();
    v[1] = 1'b0;
    step();

    // Contention, unlocked
    idx = grants.size();
    set_port(0, 1'b1, 1'b0, 32'd100, 32'd1, ADD, 4'd1);
    set_port(1, 1'b1, 1'b0, 32'hF0, 32'h0F, OR, 4'd2);
    repeat (4) step();
    for (int k = 0; k < 4; k++) check("contend_grant", 64'(grants[idx + k]), 64'(k % 2));

    // Lock bound
    idx = grants.size();
    set_port(0, 1'b1, 1'b1, 32'd1, 32'd2, ADD, 4'd5);
    set_port(1, 1'b1, 1'b0, 32'd4, 32'd6, AND, 4'd6);
    repeat (LOCK_MAX) step();
    @(posedge clock); #1;
    check("lock_cnt_clear", 64'(dut.u_arb.lock_cnt), 64'(0));
    repeat (2) step();
    for (int k = 0; k < LOCK_MAX + 2; k++)
      check("lock_grant", 64'(grants[idx + k]), 64'((k == LOCK_MAX) ? 1 : 0));
    v[0] = 1'b0; v[1] = 1'b0;
    step();

    // Illegal opcode
    set_port(0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'b01000, 4'd7);
    step();

    // Reset mid-operation: pointer left at p1 and a response register holding data
    set_port(0, 1'b1, 1'b0, 32'd9, 32'd4, ADD, 4'd11);
    step();
    @(negedge clock);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, ADD, '0);
    set_port(1, 1'b1, 1'b0, 32'd1, 32'd1, ADD, 4'd12);
    drive();
    #3;
    reset = 1'b0;
    #1;
    check_resp_zero("midreset");
    @(negedge clock);
    v[1] = 1'b0; drive();
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    prio = 0; lock_port = -1; burst = 0;
    step();
    check_resp_zero("post_reset");
    idx = grants.size();
    set_port(0, 1'b1, 1'b0, 32'd2, 32'd2, SUB, 4'd13);
    set_port(1, 1'b1, 1'b0, 32'd5, 32'd1, SUB, 4'd14);
    step();
    check("post_reset_grant", 64'(grants[idx]), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom_range(0, 3) != 0);
        lk[p] = ($urandom_range(0, 2) == 0);
        a[p]  = $urandom;
        b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
        op[p] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
        sh[p] = 5'($urandom_range(0, 31));
        tg[p] = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      end
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (2) step();
    @(posedge clock); #2;
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
